// File: rtl/fp32_pkg.sv
// Shared fp32 constants, operand-class encodings, flag bit positions and the
// normalize-stage record used by the multiplier back end.
package fp32_pkg;

  localparam int          FP32_BIAS = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} vector
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // The exponent is one bit wider than the input so the +1 adjustments never wrap
  typedef struct packed {
    logic               sign;
    logic signed [10:0] exp;
    logic [22:0]        mant;
    logic               g;
    logic               s;
    logic [1:0]         cls_a;
    logic [1:0]         cls_b;
  } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard and sticky bits.
module fp_round_rne (
  input  logic [22:0] i_mant,
  input  logic        i_g,
  input  logic        i_s,
  output logic [22:0] o_mant,
  output logic        o_carry,
  output logic        o_inexact
);

  logic w_up;

  // Ties (g=1, s=0) round up only when the kept LSB is odd
  assign w_up              = i_g & (i_s | i_mant[0]);
  assign {o_carry, o_mant} = {1'b0, i_mant} + {23'd0, w_up};
  assign o_inexact         = i_g | i_s;

endmodule

// File: rtl/f_mul_norm_round.sv
// fp32 multiplier back end: normalize (S1), round/pack/special-case (S2), valid/ready pipeline.
// Optional FP_STICKY_FLAGS_EN adds flag_clr / sticky_flg accumulation of emitted flags.
module f_mul_norm_round
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic [1:0]  in_cls_a,
  input  logic [1:0]  in_cls_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags
`ifdef FP_STICKY_FLAGS_EN
  ,
  input  logic        flag_clr,
  output logic [3:0]  sticky_flg
`endif
);

  logic               r_v1;
  s1_t                r_s1;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic [3:0]         r_out_flags;

  logic               w_s2_adv;
  logic               w_s1_adv;
  s1_t                w_s1_next;
  logic signed [10:0] w_exp_ext;
  logic [22:0]        w_mant_r;
  logic               w_carry;
  logic               w_inexact;
  logic signed [10:0] w_exp_r;
  logic               w_any_nan;
  logic               w_any_inf;
  logic               w_any_zero;
  logic [31:0]        w_data;
  logic [3:0]         w_flags;

  assign w_s2_adv  = ~r_out_valid | out_ready;
  assign w_s1_adv  = ~r_v1 | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

  assign w_exp_ext = {in_exp[9], in_exp};

  // S1: a product in [2,4) shifts right by one and bumps the exponent
  always_comb begin
    w_s1_next       = '0;
    w_s1_next.sign  = in_sign;
    w_s1_next.cls_a = in_cls_a;
    w_s1_next.cls_b = in_cls_b;
    if (in_prod[47]) begin
      w_s1_next.mant = in_prod[46:24];
      w_s1_next.g    = in_prod[23];
      w_s1_next.s    = |in_prod[22:0];
      w_s1_next.exp  = w_exp_ext + 11'sd1;
    end else begin
      w_s1_next.mant = in_prod[45:23];
      w_s1_next.g    = in_prod[22];
      w_s1_next.s    = |in_prod[21:0];
      w_s1_next.exp  = w_exp_ext;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_s1_adv) begin
      r_v1 <= in_valid;
      if (in_valid) r_s1 <= w_s1_next;
    end
  end

  fp_round_rne u_round (
    .i_mant    (r_s1.mant),
    .i_g       (r_s1.g),
    .i_s       (r_s1.s),
    .o_mant    (w_mant_r),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  assign w_exp_r    = r_s1.exp + $signed({10'd0, w_carry});
  assign w_any_nan  = (r_s1.cls_a == CLS_NAN)  | (r_s1.cls_b == CLS_NAN);
  assign w_any_inf  = (r_s1.cls_a == CLS_INF)  | (r_s1.cls_b == CLS_INF);
  assign w_any_zero = (r_s1.cls_a == CLS_ZERO) | (r_s1.cls_b == CLS_ZERO);

  // S2: special operand classes override the arithmetic result
  always_comb begin
    w_data  = '0;
    w_flags = '0;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      w_data           = FP32_QNAN;
      w_flags[FLG_INV] = ~w_any_nan;
    end else if (w_any_inf) begin
      w_data = {r_s1.sign, 8'hFF, 23'd0};
    end else if (w_any_zero) begin
      w_data = {r_s1.sign, 31'd0};
    end else if (w_exp_r >= EXP_MAX) begin
      w_data           = {r_s1.sign, 8'hFF, 23'd0};
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else if (w_exp_r <= 0) begin
      w_data           = {r_s1.sign, 31'd0};
      w_flags[FLG_UNF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_data           = {r_s1.sign, w_exp_r[7:0], w_mant_r};
      w_flags[FLG_INX] = w_inexact;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_data  <= w_data;
        r_out_flags <= w_flags;
      end
    end
  end

`ifdef FP_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  // A clear coinciding with a transfer keeps only that transfer's flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sticky <= '0;
    end else if (flag_clr) begin
      r_sticky <= (r_out_valid & out_ready) ? r_out_flags : 4'd0;
    end else if (r_out_valid & out_ready) begin
      r_sticky <= r_sticky | r_out_flags;
    end
  end

  assign sticky_flg = r_sticky;
`endif

endmodule

// File: tb/tb_f_mul_norm_round.sv
// Directed-vector bench for f_mul_norm_round: arithmetic, rounding, specials,
// backpressure and mid-flight reset, all against hand-computed results.
module tb_f_mul_norm_round;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  in_cls_a;
  logic [1:0]  in_cls_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
`ifdef FP_STICKY_FLAGS_EN
  logic        flag_clr = 1'b0;
  logic [3:0]  sticky_flg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  f_mul_norm_round dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_prod   (in_prod),
    .in_cls_a  (in_cls_a),
    .in_cls_b  (in_cls_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
`ifdef FP_STICKY_FLAGS_EN
    ,
    .flag_clr  (flag_clr),
    .sticky_flg(sticky_flg)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                       input logic [1:0] ca, input logic [1:0] cb);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_prod  = p;
    in_cls_a = ca;
    in_cls_b = cb;
  endtask

  // One vector through an empty pipeline with out_ready high: result appears after two edges
  task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] p, input logic [1:0] ca, input logic [1:0] cb,
                         input logic [31:0] exp_data, input logic [3:0] exp_flags);
    drive(s, e, p, ca, cb);
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_valid_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid_lat2"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, out_data, exp_data);
    check_eq({tag, "_flags"}, {28'd0, out_flags}, {28'd0, exp_flags});
  endtask

  initial begin
    rstn      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_cls_a  = 2'b00;
    in_cls_b  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_vec("mul_1p5x1p5",  1'b0, 10'd127, 48'h900000000000, 2'b00, 2'b00, 32'h40100000, 4'b0000);
    run_vec("rne_tie_even", 1'b0, 10'd127, 48'h400000400000, 2'b00, 2'b00, 32'h3F800000, 4'b0001);
    run_vec("rne_tie_odd",  1'b0, 10'd127, 48'h400000C00000, 2'b00, 2'b00, 32'h3F800002, 4'b0001);
    run_vec("sticky_only",  1'b0, 10'd127, 48'h400000000001, 2'b00, 2'b00, 32'h3F800000, 4'b0001);
    run_vec("round_carry",  1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 2'b00, 32'h40000000, 4'b0001);
    run_vec("overflow",     1'b0, 10'd254, 48'h800000000000, 2'b00, 2'b00, 32'h7F800000, 4'b0101);
    run_vec("ovf_by_round", 1'b1, 10'd254, 48'h7FFFFFC00000, 2'b00, 2'b00, 32'hFF800000, 4'b0101);
    run_vec("max_exp",      1'b0, 10'd254, 48'h400000000000, 2'b00, 2'b00, 32'h7F000000, 4'b0000);
    run_vec("min_normal",   1'b0, 10'd1,   48'h400000000000, 2'b00, 2'b00, 32'h00800000, 4'b0000);
    run_vec("underflow",    1'b0, 10'd0,   48'h400000000000, 2'b00, 2'b00, 32'h00000000, 4'b0011);
    run_vec("underflow_neg",1'b1, 10'h3FB, 48'h800000000000, 2'b00, 2'b00, 32'h80000000, 4'b0011);
    run_vec("inf_x_zero",   1'b0, 10'd127, 48'h400000000000, 2'b10, 2'b01, 32'h7FC00000, 4'b1000);
    run_vec("nan_x_zero",   1'b1, 10'd127, 48'h400000000000, 2'b11, 2'b01, 32'h7FC00000, 4'b0000);
    run_vec("inf_x_norm",   1'b1, 10'd127, 48'h400000000000, 2'b00, 2'b10, 32'hFF800000, 4'b0000);
    run_vec("zero_x_norm",  1'b1, 10'd127, 48'h400000000000, 2'b01, 2'b00, 32'h80000000, 4'b0000);
    @(posedge clk); #1;
    check_eq("drain_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back inputs while the sink stalls
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h900000000000, 2'b00, 2'b00);
    check_eq("bp_rdy_a", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 10'd127, 48'h400000400000, 2'b00, 2'b00);
    check_eq("bp_rdy_b", {31'd0, in_ready}, 32'd1);
    check_eq("bp_valid_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 2'b00);
    check_eq("bp_rdy_c_blocked", {31'd0, in_ready}, 32'd0);
    check_eq("bp_valid_a", {31'd0, out_valid}, 32'd1);
    check_eq("bp_data_a", out_data, 32'h40100000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("bp_rdy_held", {31'd0, in_ready}, 32'd0);
      check_eq("bp_data_stable", out_data, 32'h40100000);
      check_eq("bp_flags_stable", {28'd0, out_flags}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_rdy_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_data_b", out_data, 32'h3F800000);
    check_eq("bp_flags_b", {28'd0, out_flags}, 32'd1);
    @(posedge clk); #1;
    check_eq("bp_valid_c", {31'd0, out_valid}, 32'd1);
    check_eq("bp_data_c", out_data, 32'h40000000);
    @(posedge clk); #1;
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two results in flight
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h900000000000, 2'b00, 2'b00);
    @(posedge clk); #1;
    drive(1'b0, 10'd254, 48'h800000000000, 2'b00, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid_data", out_data, 32'd0);
    check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("rst_post_quiet", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
